// File: rtl/sar_conv_sequencer_pkg.sv
// Shared types and width helpers for the SAR conversion sequencer.
// Holds the FSM state enum and the derived accumulator/counter/pointer widths.
package sar_conv_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_WAIT_SLOT,
    S_EMIT
  } state_t;

  function automatic int acc_w(input int w, input int a);
    return w + a;
  endfunction

  function automatic int cnt_w(input int a);
    return a + 1;
  endfunction

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// Small synchronous FIFO holding averaged samples.
// Head entry is read straight from the storage registers.
module sar_result_fifo
  import sar_conv_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];

  // A pop in the same cycle frees the slot a full FIFO would block.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_rd) r_rd <= r_rd + PTR_W'(1);
      if (w_wr && !w_rd) r_cnt <= r_cnt + (PTR_W+1)'(1);
      else if (w_rd && !w_wr) r_cnt <= r_cnt - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Paces 4-phase go/valid requests to the SAR controller, averages
// 2^AVG_LOG2 results per sample and queues samples for downstream.
module sar_conv_sequencer
  import sar_conv_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int AVG_LOG2   = 2,
  parameter int PERIOD     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             go,
  input  logic             valid,
  input  logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int ACC_W = acc_w(WIDTH, AVG_LOG2);
  localparam int CNT_W = cnt_w(AVG_LOG2);
  localparam int PER_W = $clog2(PERIOD);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] N_CONV = CNT_W'(2 ** AVG_LOG2);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [PER_W-1:0] r_per;
  logic [TO_W-1:0]  r_to;
  logic             r_terr;
  logic             r_ovf;
  logic             w_go;
  logic             w_load;
  logic             w_add;
  logic             w_clr;
  logic             w_tout;
  logic             w_emit;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_avg;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_load = 1'b0;
    w_add  = 1'b0;
    w_clr  = 1'b0;
    w_tout = 1'b0;
    w_emit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next = S_REQ;
          w_load = 1'b1;
        end
      end
      S_REQ: begin
        w_go = 1'b1;
        if (valid) begin
          w_add  = 1'b1;
          w_next = S_RELEASE;
        end else if (r_to == TO_MAX) begin
          w_tout = 1'b1;
          w_clr  = 1'b1;
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!valid) begin
          if (r_cnt == N_CONV) begin
            w_next = S_EMIT;
          end else if (!enable) begin
            w_clr  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_WAIT_SLOT;
          end
        end
      end
      S_WAIT_SLOT: begin
        if (!enable) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end else if (r_per == '0) begin
          w_next = S_REQ;
          w_load = 1'b1;
        end
      end
      S_EMIT: begin
        w_emit = 1'b1;
        w_clr  = 1'b1;
        w_next = enable ? S_WAIT_SLOT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Period timer runs freely after each request so WAIT_SLOT can release early.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_per  <= '0;
      r_to   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_terr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_load) r_per <= PER_W'(PERIOD - 1);
      else if (r_per != '0) r_per <= r_per - PER_W'(1);
      if (w_load) r_to <= '0;
      else if (r_state == S_REQ) r_to <= r_to + TO_W'(1);
      if (w_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_add) begin
        r_acc <= r_acc + ACC_W'(result);
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_tout) r_terr <= 1'b1;
      r_ovf <= w_emit && w_full && !w_pop;
    end
  end

  assign w_avg  = WIDTH'(r_acc >> AVG_LOG2);
  assign w_pop  = out_valid && out_ready;
  assign w_push = w_emit;

  sar_result_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data (w_avg),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (out_data)
  );

  assign go          = w_go;
  assign out_valid   = !w_empty;
  assign busy        = (r_state != S_IDLE);
  assign overflow    = r_ovf;
  assign timeout_err = r_terr;

endmodule
